// File: rtl/offchip_line_bridge.sv
`default_nettype none
// ============================================================================
// Module  : offchip_line_bridge
// Brief   : Cache-line read/write bridge onto a narrow external word bus.
//           Optional per-beat ack watchdog: define OFFCHIP_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module offchip_line_bridge #(
    parameter int LINE_BYTES     = 16,
    parameter int ADDR_W         = 32,
    parameter int BUS_W          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    offchip_mem_read_en,
    input  logic                    offchip_mem_write_en,
    input  logic [ADDR_W-1:0]       offchip_mem_addr,
    input  logic [LINE_BYTES*8-1:0] offchip_mem_wdata,
    output logic [LINE_BYTES*8-1:0] offchip_mem_data,
    output logic                    offchip_mem_ready,
    output logic                    offchip_mem_err,
    output logic                    ext_req,
    output logic                    ext_we,
    output logic [ADDR_W-1:0]       ext_addr,
    output logic [BUS_W-1:0]        ext_wdata,
    input  logic [BUS_W-1:0]        ext_rdata,
    input  logic                    ext_ack
);

    localparam int C_LINE_W  = LINE_BYTES * 8;
    localparam int C_NBEATS  = C_LINE_W / BUS_W;
    localparam int C_BEAT_SH = $clog2(BUS_W / 8);
    localparam int C_K_W     = (C_NBEATS > 1) ? $clog2(C_NBEATS) : 1;

    localparam logic [2:0] C_IDLE     = 3'd0;
    localparam logic [2:0] C_RD_BEAT  = 3'd1;
    localparam logic [2:0] C_WR_BEAT  = 3'd2;
    localparam logic [2:0] C_RESP     = 3'd3;
    localparam logic [2:0] C_WAIT_REL = 3'd4;

    logic [2:0]          r_state;
    logic [C_K_W-1:0]    r_k;
    logic [ADDR_W-1:0]   r_base;
    logic [C_LINE_W-1:0] r_wline;
    logic [C_LINE_W-1:0] r_rline;

    logic [C_K_W-1:0]    w_k_next;
    logic                w_last;
    logic                w_in_beat;
    logic                w_timeout;
    logic [ADDR_W-1:0]   w_line_base;
    logic [ADDR_W-1:0]   w_next_addr;
    logic [C_LINE_W-1:0] w_fill;

    assign w_k_next    = r_k + C_K_W'(1);
    assign w_last      = (r_k == C_K_W'(C_NBEATS - 1));
    assign w_in_beat   = (r_state == C_RD_BEAT) || (r_state == C_WR_BEAT);
    assign w_line_base = offchip_mem_addr & ~ADDR_W'(LINE_BYTES - 1);
    assign w_next_addr = r_base + (ADDR_W'(w_k_next) << C_BEAT_SH);

    // Line buffer with the beat being acknowledged this cycle merged in
    always_comb begin
        w_fill = r_rline;
        if ((r_state == C_RD_BEAT) && ext_ack) begin
            w_fill[r_k*BUS_W +: BUS_W] = ext_rdata;
        end
    end

`ifdef OFFCHIP_TIMEOUT_EN
    localparam int C_TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [C_TO_W-1:0] r_tcnt;
    logic              r_err;

    assign w_timeout       = ext_req && !ext_ack && (r_tcnt == C_TO_W'(TIMEOUT_CYCLES - 1));
    assign offchip_mem_err = r_err;

    // Counts stalled cycles of the current beat; any ack starts a fresh beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_in_beat && w_timeout;
            if (!ext_req || ext_ack) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + C_TO_W'(1);
            end
        end
    end
`else
    assign w_timeout       = 1'b0;
    assign offchip_mem_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state           <= C_IDLE;
            r_k               <= '0;
            r_base            <= '0;
            r_wline           <= '0;
            r_rline           <= '0;
            ext_req           <= 1'b0;
            ext_we            <= 1'b0;
            ext_addr          <= '0;
            ext_wdata         <= '0;
            offchip_mem_ready <= 1'b0;
            offchip_mem_data  <= '0;
        end else begin
            offchip_mem_ready <= 1'b0;
            case (r_state)
                C_IDLE: begin
                    if (offchip_mem_write_en) begin
                        r_base    <= w_line_base;
                        r_wline   <= offchip_mem_wdata;
                        r_k       <= '0;
                        ext_req   <= 1'b1;
                        ext_we    <= 1'b1;
                        ext_addr  <= w_line_base;
                        ext_wdata <= offchip_mem_wdata[BUS_W-1:0];
                        r_state   <= C_WR_BEAT;
                    end else if (offchip_mem_read_en) begin
                        r_base    <= w_line_base;
                        r_rline   <= '0;
                        r_k       <= '0;
                        ext_req   <= 1'b1;
                        ext_we    <= 1'b0;
                        ext_addr  <= w_line_base;
                        ext_wdata <= '0;
                        r_state   <= C_RD_BEAT;
                    end
                end
                C_RD_BEAT, C_WR_BEAT: begin
                    if (ext_ack) begin
                        if (r_state == C_RD_BEAT) begin
                            r_rline <= w_fill;
                        end
                        if (w_last) begin
                            ext_req           <= 1'b0;
                            ext_we            <= 1'b0;
                            offchip_mem_ready <= 1'b1;
                            r_state           <= C_RESP;
                            if (r_state == C_RD_BEAT) begin
                                offchip_mem_data <= w_fill;
                            end
                        end else begin
                            r_k       <= w_k_next;
                            ext_addr  <= w_next_addr;
                            ext_wdata <= r_wline[w_k_next*BUS_W +: BUS_W];
                        end
                    end else if (w_timeout) begin
                        // Unfilled beats stay zero from the clear at read start
                        ext_req           <= 1'b0;
                        ext_we            <= 1'b0;
                        offchip_mem_ready <= 1'b1;
                        r_state           <= C_RESP;
                        if (r_state == C_RD_BEAT) begin
                            offchip_mem_data <= r_rline;
                        end
                    end
                end
                C_RESP: begin
                    r_state <= C_WAIT_REL;
                end
                C_WAIT_REL: begin
                    if (!offchip_mem_read_en && !offchip_mem_write_en) begin
                        r_state <= C_IDLE;
                    end
                end
                default: begin
                    r_state <= C_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
